// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-to-decode valid/ready bundle.
// master = fetch side, slave = decode side.
interface fetch_unit_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;

  modport master (
    output dec_valid,
    output dec_inst,
    output dec_pc,
    output dec_pred_taken,
    input  dec_ready
  );

  modport slave (
    input  dec_valid,
    input  dec_inst,
    input  dec_pc,
    input  dec_pred_taken,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem read port and instruction queue to decode.
// Optional JAL predecode enabled by FETCH_JAL_PREDECODE_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [31:0]               imem_addr,
  input  logic [31:0]               imem_inst,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  fetch_unit_if.master              dec,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   ent_inst_q [QDEPTH];
  logic [31:0]   ent_pc_q   [QDEPTH];
  logic          ent_pred_q [QDEPTH];

  logic [31:0]   last_inst_q, last_inst_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          last_pred_q, last_pred_d;

  logic [31:0]   next_pc;
  logic          pred;
  logic          empty;
  logic          push;
  logic          pop;

`ifdef FETCH_JAL_PREDECODE_EN
  logic [31:0] jal_off;

  always_comb begin
    jal_off = {{11{imem_inst[31]}},
               imem_inst[31],
               imem_inst[19:12],
               imem_inst[20],
               imem_inst[30:21],
               1'b0};
    pred    = imem_inst[6:0] == 7'b1101111;
    next_pc = pred ? pc_q + jal_off
                   : pc_q + 32'd4;
  end
`else
  always_comb begin
    pred    = 1'b0;
    next_pc = pc_q + 32'd4;
  end
`endif

  assign imem_addr = pc_q;
  assign q_count   = cnt_q;
  assign empty     = cnt_q == '0;

  // Empty queue shows the last popped entry, not stale slots.
  assign dec.dec_valid = ~empty & ~redirect_valid;
  assign dec.dec_inst  = empty ? last_inst_q
                               : ent_inst_q[rd_ptr_q];
  assign dec.dec_pc    = empty ? last_pc_q
                               : ent_pc_q[rd_ptr_q];
  assign dec.dec_pred_taken = empty ? last_pred_q
                                    : ent_pred_q[rd_ptr_q];

  assign pop  = dec.dec_valid & dec.dec_ready;
  assign push = ~redirect_valid & ((cnt_q != FULL) | pop);

  always_comb begin
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    last_inst_d = last_inst_q;
    last_pc_d   = last_pc_q;
    last_pred_d = last_pred_q;
    unique case (1'b1)
      redirect_valid: begin
        cnt_d    = '0;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        pc_d     = {redirect_pc[31:2], 2'b00};
      end
      default: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          pc_d     = next_pc;
        end
        if (pop) begin
          rd_ptr_d    = rd_ptr_q + AW'(1);
          last_inst_d = ent_inst_q[rd_ptr_q];
          last_pc_d   = ent_pc_q[rd_ptr_q];
          last_pred_d = ent_pred_q[rd_ptr_q];
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      last_inst_q <= NOP;
      last_pc_q   <= '0;
      last_pred_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      last_inst_q <= last_inst_d;
      last_pc_q   <= last_pc_d;
      last_pred_q <= last_pred_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~rst) begin
      ent_inst_q[wr_ptr_q] <= imem_inst;
      ent_pc_q[wr_ptr_q]   <= pc_q;
      ent_pred_q[wr_ptr_q] <= pred;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit
// against a queue-based reference model.
module tb_fetch_unit;

  localparam int QD = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  q_count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit_if dif();

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dif),
    .q_count        (q_count)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [logic [31:0]];
  int prog_ver = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return {a[24:0] ^ 25'h1a5f3c7, 7'h13};
  endfunction

  always @(imem_addr or prog_ver) imem_inst = mem_rd(imem_addr);

  ent_t        mq[$];
  ent_t        m_last;
  logic [31:0] m_pc;

  function automatic logic is_jal(input logic [31:0] w);
`ifdef FETCH_JAL_PREDECODE_EN
    return w[6:0] == 7'h6f;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] jal_imm(input logic [31:0] w);
    int v;
    v = (int'(w[30:21]) * 2) + (int'(w[20]) * 2048)
      + (int'(w[19:12]) * 4096) - (w[31] ? 1048576 : 0);
    return 32'(v);
  endfunction

  task automatic model_step();
    ent_t e;
    logic pop;
    logic push;
    if (rst) begin
      m_pc = RPC;
      mq.delete();
      m_last = '{pc: 32'h0, inst: 32'h13, pred: 1'b0};
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      pop  = (mq.size() > 0) && dif.dec_ready;
      push = (mq.size() < QD) || pop;
      if (pop) m_last = mq.pop_front();
      if (push) begin
        e.pc   = m_pc;
        e.inst = mem_rd(m_pc);
        e.pred = is_jal(e.inst);
        mq.push_back(e);
        m_pc = e.pred ? m_pc + jal_imm(e.inst) : m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t exp_head();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    dif.dec_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    dif.dec_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (dif.dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", dif.dec_valid);
    end
    n_tests++;
    if (q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_qcount got %0d want 0", q_count);
    end
    n_tests++;
    if (dif.dec_inst !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL reset_inst got %h want 00000013", dif.dec_inst);
    end
    n_tests++;
    if (dif.dec_pc !== 32'h0 || dif.dec_pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pc got %h/%b want 0/0",
               dif.dec_pc, dif.dec_pred_taken);
    end
    n_tests++;
    if (imem_addr !== RPC) begin
      n_fail++;
      $display("FAIL reset_addr got %h want %h", imem_addr, RPC);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    dif.dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_tests++;
      if (dif.dec_valid !== 1'b1 || dif.dec_pc !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL stream_pc%0d got v=%b pc=%h want v=1 pc=%h",
                 i, dif.dec_valid, dif.dec_pc, 32'(i * 4));
      end
    end
    do_reset();
    dif.dec_ready = 1'b1;
    tick();
    #1;
    n_tests++;
    if (dif.dec_inst !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL stream_first_inst got %h want 00500093",
               dif.dec_inst);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    #1;
    n_tests++;
    if (q_count !== 3'd4 || imem_addr !== 32'h10 ||
        dif.dec_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_full got cnt=%0d addr=%h pc=%h want 4/10/0",
               q_count, imem_addr, dif.dec_pc);
    end
    dif.dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (dif.dec_valid !== 1'b1 || dif.dec_pc !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL bp_drain%0d got v=%b pc=%h want v=1 pc=%h",
                 i, dif.dec_valid, dif.dec_pc, 32'(i * 4));
      end
      tick();
      if (i == 0) begin
        n_tests++;
        if (q_count !== 3'd4 || imem_addr !== 32'h14) begin
          n_fail++;
          $display("FAIL bp_pushpop got cnt=%0d addr=%h want 4/14",
                   q_count, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1E;
    #1;
    n_tests++;
    if (dif.dec_valid !== 1'b0 || q_count !== 3'd4) begin
      n_fail++;
      $display("FAIL redir_now got v=%b cnt=%0d want 0/4",
               dif.dec_valid, q_count);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (q_count !== 3'd0 || imem_addr !== 32'h1C ||
        dif.dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_next got cnt=%0d addr=%h v=%b want 0/1c/0",
               q_count, imem_addr, dif.dec_valid);
    end
    n_tests++;
    if (dif.dec_inst !== 32'h13 || dif.dec_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL redir_hold got %h/%h want 00000013/0",
               dif.dec_inst, dif.dec_pc);
    end
    dif.dec_ready = 1'b1;
    tick();
    #1;
    n_tests++;
    if (dif.dec_valid !== 1'b1 || dif.dec_pc !== 32'h1C) begin
      n_fail++;
      $display("FAIL redir_target got v=%b pc=%h want 1/1c",
               dif.dec_valid, dif.dec_pc);
    end
  endtask

  task automatic test_jal();
    logic [31:0] exp_pc [5];
    logic        exp_pred3;
    logic [31:0] exp_after;
`ifdef FETCH_JAL_PREDECODE_EN
    exp_pc    = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h1C};
    exp_pred3 = 1'b1;
    exp_after = 32'h08;
`else
    exp_pc    = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_pred3 = 1'b0;
    exp_after = 32'h18;
`endif
    prog[32'h0C] = 32'h0100_01EF;
    prog[32'h14] = 32'hFF5F_F06F;
    prog_ver++;
    do_reset();
    dif.dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      n_tests++;
      if (dif.dec_pc !== exp_pc[i] ||
          (i == 3 && dif.dec_pred_taken !== exp_pred3)) begin
        n_fail++;
        $display("FAIL jal_seq%0d got pc=%h pred=%b want pc=%h",
                 i, dif.dec_pc, dif.dec_pred_taken, exp_pc[i]);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    #1;
    n_tests++;
    if (dif.dec_pc !== exp_after) begin
      n_fail++;
      $display("FAIL jal_back got pc=%h want %h", dif.dec_pc, exp_after);
    end
    prog.delete(32'h0C);
    prog.delete(32'h14);
    prog_ver++;
  endtask

  task automatic test_wrap();
    dif.dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    #1;
    n_tests++;
    if (dif.dec_pc !== 32'hFFFF_FFFC || dif.dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_top got pc=%h v=%b want fffffffc/1",
               dif.dec_pc, dif.dec_valid);
    end
    tick();
    #1;
    n_tests++;
    if (dif.dec_pc !== 32'h0 || dif.dec_inst !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL wrap_zero got pc=%h inst=%h want 0/00500093",
               dif.dec_pc, dif.dec_inst);
    end
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      dif.dec_ready  = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc    = $urandom;
      #1;
      h = exp_head();
      n_tests++;
      if (dif.dec_valid !== ((mq.size() > 0) && !redirect_valid) ||
          dif.dec_pc !== h.pc || dif.dec_inst !== h.inst ||
          dif.dec_pred_taken !== h.pred ||
          q_count !== 3'(mq.size()) || imem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL rand%0d got v=%b pc=%h i=%h c=%0d a=%h want pc=%h i=%h c=%0d a=%h",
                 i, dif.dec_valid, dif.dec_pc, dif.dec_inst, q_count,
                 imem_addr, h.pc, h.inst, mq.size(), m_pc);
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    prog[32'h0] = 32'h0050_0093;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    dif.dec_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_jal();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
